// File: rtl/uart_pkg.sv
// Shared definitions for the UART/ALU datapath: default widths, ALU opcodes
// and the sequencing FSM state encoding.
package uart_pkg;

    localparam int NB_DATA_DEF = 8;
    localparam int NB_OP_DEF   = 6;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_WAIT_TX = 3'd4;

endpackage

// File: rtl/uart_alu_if_alu.sv
// Purely combinational ALU; undefined opcodes yield zero, arithmetic wraps
// and shifts use the full B value as the shift amount.
module alu
    import uart_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF
) (
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    input  logic [NB_OP-1:0]   i_op,
    output logic [NB_DATA-1:0] o_res
);

    // Opcode decode and result selection
    always_comb begin
        o_res = {NB_DATA{1'b0}};
        case (i_op)
            OP_ADD:  o_res = i_a + i_b;
            OP_SUB:  o_res = i_a - i_b;
            OP_AND:  o_res = i_a & i_b;
            OP_OR:   o_res = i_a | i_b;
            OP_XOR:  o_res = i_a ^ i_b;
            OP_NOR:  o_res = ~(i_a | i_b);
            OP_SRA:  o_res = $signed(i_a) >>> i_b;
            OP_SRL:  o_res = i_a >> i_b;
            default: o_res = {NB_DATA{1'b0}};
        endcase
    end

endmodule

// File: rtl/uart_alu_if.sv
// Sequences received bytes (A, B, opcode) into the ALU and hands the result
// to the transmitter with a start/done handshake; flags bytes dropped while busy.
module uart_alu_if
    import uart_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_overrun
);

    logic [2:0]         state_q, state_d;
    logic [NB_DATA-1:0] a_q, a_d;
    logic [NB_DATA-1:0] b_q, b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic [NB_OP-1:0]   alu_op_s;
    logic [NB_DATA-1:0] alu_res_s;
    logic               op_capture_s;

    // The ALU sees the incoming opcode on the capture cycle so the result lands with it
    assign op_capture_s = (state_q == ST_WAIT_OP) && i_rx_done;

    // ALU opcode source: live byte while capturing, stored opcode otherwise
    always_comb begin
        if (op_capture_s) begin
            alu_op_s = i_rx_data[NB_OP-1:0];
        end else begin
            alu_op_s = op_q;
        end
    end

    alu #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_alu (
        .i_a   (a_q),
        .i_b   (b_q),
        .i_op  (alu_op_s),
        .o_res (alu_res_s)
    );

    // Next-state, operand capture and overrun logic
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        tx_data_d = tx_data_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_WAIT_A: begin
                if (i_rx_done) begin
                    a_d     = i_rx_data;
                    state_d = ST_WAIT_B;
                end else begin
                    state_d = ST_WAIT_A;
                end
            end
            ST_WAIT_B: begin
                if (i_rx_done) begin
                    b_d     = i_rx_data;
                    state_d = ST_WAIT_OP;
                end else begin
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_OP: begin
                if (op_capture_s) begin
                    op_d      = i_rx_data[NB_OP-1:0];
                    tx_data_d = alu_res_s;
                    state_d   = ST_SEND;
                end else begin
                    state_d = ST_WAIT_OP;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT_TX;
                if (i_rx_done) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = ST_WAIT_A;
                end else begin
                    state_d = ST_WAIT_TX;
                end
                if (i_rx_done) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end
            default: begin
                state_d = ST_WAIT_A;
            end
        endcase
        tx_start_d = (state_q == ST_SEND);
        busy_d     = (state_d == ST_SEND) || (state_d == ST_WAIT_TX);
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_WAIT_A;
            a_q        <= {NB_DATA{1'b0}};
            b_q        <= {NB_DATA{1'b0}};
            op_q       <= {NB_OP{1'b0}};
            tx_data_q  <= {NB_DATA{1'b0}};
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_busy     = busy_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_if.sv
// Directed-vector bench for uart_alu_if: handshake latency, ALU opcodes,
// overrun behaviour, mid-operation reset and back-to-back byte reception.
module tb_uart_alu_if;

    logic       clk;
    logic       reset;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       overrun;

    int vectors;
    int miscompares;

    uart_alu_if #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_rx_done  (rx_done),
        .i_rx_data  (rx_data),
        .i_tx_done  (tx_done),
        .o_tx_start (tx_start),
        .o_tx_data  (tx_data),
        .o_busy     (busy),
        .o_overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One byte, one rx_done pulse; returns 1 time unit after the capturing edge
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_done = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic tx_done_pulse();
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    // Full transaction; only observes, the calling test compares
    task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          output logic [7:0] data, output int pulses, output int first_pos,
                          output logic busy_n, output logic busy_end);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        busy_n    = busy;
        data      = tx_data;
        pulses    = 0;
        first_pos = -1;
        if (tx_start) begin
            pulses    = pulses + 1;
            first_pos = 0;
        end
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (tx_start) begin
                pulses = pulses + 1;
                if (first_pos < 0) first_pos = i;
            end
        end
        tx_done_pulse();
        busy_end = busy;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_add();
        logic [7:0] d;
        int p, pos;
        logic bn, be;
        do_txn(8'h05, 8'h03, 8'h20, d, p, pos, bn, be);
        vectors++; if (d !== 8'h08) begin miscompares++; $display("FAIL add_data: got %h want 08", d); end
        vectors++; if (p !== 1) begin miscompares++; $display("FAIL add_pulses: got %0d want 1", p); end
        vectors++; if (pos !== 1) begin miscompares++; $display("FAIL add_pulse_pos: got %0d want 1", pos); end
        vectors++; if (bn !== 1'b1) begin miscompares++; $display("FAIL add_busy_send: got %b want 1", bn); end
        vectors++; if (be !== 1'b0) begin miscompares++; $display("FAIL add_busy_done: got %b want 0", be); end
        vectors++; if (tx_data !== 8'h08) begin miscompares++; $display("FAIL add_hold: got %h want 08", tx_data); end
    endtask

    task automatic test_ops();
        logic [7:0] va [10] = '{8'h03, 8'h80, 8'h80, 8'h0F, 8'h12, 8'h0F, 8'h80, 8'hFF, 8'h01, 8'hF0};
        logic [7:0] vb [10] = '{8'h05, 8'h02, 8'h09, 8'hF0, 8'h34, 8'hFF, 8'h09, 8'h02, 8'h02, 8'h3C};
        logic [7:0] vo [10] = '{8'h22, 8'h03, 8'h02, 8'h27, 8'h3F, 8'h26, 8'h03, 8'h20, 8'hE0, 8'h24};
        logic [7:0] ve [10] = '{8'hFE, 8'hE0, 8'h00, 8'h00, 8'h00, 8'hF0, 8'hFF, 8'h01, 8'h03, 8'h30};
        logic [7:0] d;
        int p, pos;
        logic bn, be;
        for (int i = 0; i < 10; i++) begin
            do_txn(va[i], vb[i], vo[i], d, p, pos, bn, be);
            vectors++; if (d !== ve[i]) begin miscompares++; $display("FAIL op%0d_data: got %h want %h", i, d, ve[i]); end
            vectors++; if (p !== 1 || be !== 1'b0) begin miscompares++; $display("FAIL op%0d_handshake: got pulses %0d busy %b want 1 0", i, p, be); end
        end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        int p, pos;
        logic bn, be;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h20);
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_pre: got %b want 0", overrun); end
        send_byte(8'hAA);
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set: got %b want 1", overrun); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ovr_state_kept: got busy %b want 1", busy); end
        vectors++; if (tx_data !== 8'h33) begin miscompares++; $display("FAIL ovr_hold: got %h want 33", tx_data); end
        @(posedge clk); #1;
        rx_done = 1'b1;
        rx_data = 8'hAA;
        tx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        tx_done = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ovr_coincide_busy: got %b want 0", busy); end
        do_txn(8'h01, 8'h01, 8'h20, d, p, pos, bn, be);
        vectors++; if (d !== 8'h02) begin miscompares++; $display("FAIL ovr_next_data: got %h want 02", d); end
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int p, pos;
        logic bn, be;
        send_byte(8'h07);
        do_reset();
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        do_txn(8'h02, 8'h03, 8'h24, d, p, pos, bn, be);
        vectors++; if (d !== 8'h02) begin miscompares++; $display("FAIL rst_and_data: got %h want 02", d); end
        vectors++; if (p !== 1) begin miscompares++; $display("FAIL rst_and_pulses: got %0d want 1", p); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        int p, pos;
        logic bn, be;
        @(posedge clk); #1;
        rx_done = 1'b1;
        rx_data = 8'h10;
        @(posedge clk); #1;
        rx_data = 8'h20;
        @(posedge clk); #1;
        rx_data = 8'h25;
        @(posedge clk); #1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        vectors++; if (tx_data !== 8'h30) begin miscompares++; $display("FAIL b2b_data: got %h want 30", tx_data); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy: got %b want 1", busy); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        tx_done_pulse();
        tx_done_pulse();
        vectors++; if (busy !== 1'b0 || tx_start !== 1'b0) begin miscompares++; $display("FAIL idle_tx_done: got busy %b start %b want 0 0", busy, tx_start); end
        do_txn(8'h04, 8'h05, 8'h20, d, p, pos, bn, be);
        vectors++; if (d !== 8'h09) begin miscompares++; $display("FAIL idle_next_data: got %h want 09", d); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        rx_done     = 1'b0;
        rx_data     = 8'h00;
        tx_done     = 1'b0;
        test_reset();
        test_add();
        test_ops();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_alu_if.md
# uart_alu_if

Byte-sequencing interface that sits directly downstream of `mod_rx` and upstream of `mod_tx` in the UART/ALU datapath.
- Consumes received bytes in the fixed order: operand A, operand B, opcode.
- Evaluates the result in a combinational ALU sub-module.
- Hands the 8-bit result to the transmitter with a start/done handshake.
- Flags any byte that arrives while a result is still being sent.

## Interface
Parameters:
- `NB_DATA`, 8, data/operand/result width (equals `mod_rx` data width)
- `NB_OP`, 6, opcode width; opcode taken from `i_rx_data[NB_OP-1:0]`, upper bits ignored

Ports:
- `i_clk`  in  1  system clock (same clock as `baudrate_gen`/`mod_rx`)
- `i_reset`  in  1  synchronous, active-high reset
- `i_rx_done`  in  1  one-cycle pulse from `mod_rx`: `i_rx_data` valid this cycle
- `i_rx_data`  in  NB_DATA  received byte
- `i_tx_done`  in  1  one-cycle pulse from `mod_tx`: frame fully sent
- `o_tx_start`  out  1  one-cycle pulse requesting transmission of `o_tx_data`
- `o_tx_data`  out  NB_DATA  registered ALU result, held stable until next result
- `o_busy`  out  1  high in SEND and WAIT_TX
- `o_overrun`  out  1  sticky; set when a byte is dropped, cleared only by reset

## Operation
- FSM states: WAIT_A, WAIT_B, WAIT_OP, SEND, WAIT_TX.
- WAIT_A, `i_rx_done`=1: latch A, go to WAIT_B.
- WAIT_B, `i_rx_done`=1: latch B, go to WAIT_OP.
- WAIT_OP, `i_rx_done`=1: latch opcode; register the ALU result (computed from A, B and the incoming opcode) into `o_tx_data`; go to SEND.
- SEND: assert `o_tx_start` for exactly one cycle, then go to WAIT_TX unconditionally.
- WAIT_TX, `i_tx_done`=1: go to WAIT_A.
- `i_rx_done` in SEND or WAIT_TX: byte dropped, `o_overrun` set, state unaffected. This includes `i_rx_done` coinciding with `i_tx_done`: transition to WAIT_A, byte dropped, overrun set.
- `i_tx_done` outside WAIT_TX: ignored.
- Opcodes (binary, 6 bits):
  - ADD 100000: A+B
  - SUB 100010: A−B
  - AND 100100
  - OR 100101
  - XOR 100110
  - NOR 100111
  - SRA 000011: $signed(A) >>> B
  - SRL 000010: A >> B
- Undefined opcode: result 0; no error flag.
- Arithmetic wraps modulo 2^NB_DATA; no carry or overflow output.
- Shift amount is the full B value: B ≥ NB_DATA gives 0 for SRL and all-sign-bits for SRA.
- Reset mid-operation: the partially collected A/B is discarded and the next byte is treated as A.

## Timing
- Reset values: state=WAIT_A, A=B=opcode=0, `o_tx_data`=0, `o_tx_start`=0, `o_busy`=0, `o_overrun`=0.
- All outputs are registered.
- Latency: opcode `i_rx_done` sampled at edge N → `o_tx_data` valid after N → `o_tx_start` high for the cycle after N+1, low after N+2.
- `o_busy` rises with SEND (after edge N) and falls the edge `i_tx_done` is sampled.
- `o_tx_data` holds its value through WAIT_TX and until the next opcode capture.
- Back-to-back `i_rx_done` on consecutive cycles is accepted in WAIT_A/WAIT_B/WAIT_OP; no minimum spacing.
- `o_overrun` sets the edge after the offending `i_rx_done`.

## Structure
- Shared package (`uart_pkg`):
  - opcode localparams (OP_ADD … OP_NOR)
  - FSM state encoding (3 bits)
  - default `NB_DATA`/`NB_OP`
- One sub-module, `alu`:
  - purely combinational
  - parameters `NB_DATA`, `NB_OP`
  - ports `i_a`, `i_b`, `i_op`, `o_res`
  - reusable by the standalone ALU bench
- FSM, operand registers and flags live in `uart_alu_if`.

## Test plan
- Bytes 0x05, 0x03, 0x20 (ADD) → one `o_tx_start` pulse two cycles after the third `i_rx_done`, `o_tx_data`=0x08; after `i_tx_done`, `o_busy`=0.
- SUB 0x03−0x05 → 0xFE. SRA A=0x80, B=0x02 → 0xE0. SRL A=0x80, B=0x09 → 0x00. NOR 0x0F/0xF0 → 0x00.
- Undefined opcode 0x3F with A=0x12, B=0x34 → `o_tx_data`=0x00, handshake otherwise normal.
- Extra `i_rx_done` (0xAA) during WAIT_TX, including on the same cycle as `i_tx_done` → `o_overrun`=1, stays 1; next triple 0x01, 0x01, 0x20 still yields 0x02.
- `i_reset` pulse after A=0x07 received → next bytes 0x02, 0x03, 0x24 (AND) produce 0x02, and `o_overrun` is 0.
- Consecutive-cycle `i_rx_done` pulses 0x10, 0x20, 0x25 (OR) → 0x30; `i_tx_done` asserted while in WAIT_A → ignored, state unchanged.
